// File: rtl/noc_pkg.sv
// Shared helpers for the gather network: source-id width derivation.
package noc_pkg;

  // Source-id width for a given node count; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned num_node);
    return (num_node > 1) ? $clog2(num_node) : 1;
  endfunction

endpackage

// File: rtl/linear_network_gather_seq_if.sv
// Producer-side and consumer-side signals of the gather network.
interface linear_network_gather_seq_if
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_NODE   = 4
);
  localparam int unsigned ID_WIDTH = id_width(NUM_NODE);

  logic                           i_en;
  logic [NUM_NODE-1:0]            i_valid;
  logic [NUM_NODE*DATA_WIDTH-1:0] i_data_bus;
  logic [NUM_NODE-1:0]            o_ready;
  logic                           o_valid;
  logic [DATA_WIDTH-1:0]          o_data_bus;
  logic [ID_WIDTH-1:0]            o_src_id;
  logic                           i_ready;

  modport master (
    output i_en, i_valid, i_data_bus, i_ready,
    input  o_ready, o_valid, o_data_bus, o_src_id
  );

  modport slave (
    input  i_en, i_valid, i_data_bus, i_ready,
    output o_ready, o_valid, o_data_bus, o_src_id
  );
endinterface

// File: rtl/gather_2x1_rr_seq.sv
// One registered 2:1 merge stage: upstream flit vs local node, round-robin on contention.
module gather_2x1_rr_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned STAGE_ID   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  up_valid_i,
  input  logic [DATA_WIDTH-1:0] up_data_i,
  input  logic [ID_WIDTH-1:0]   up_src_i,
  input  logic                  loc_valid_i,
  input  logic [DATA_WIDTH-1:0] loc_data_i,
  input  logic                  dn_take_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ID_WIDTH-1:0]   src_o,
  output logic                  loc_ready_o,
  output logic                  up_take_o,
  output logic                  adv_o
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   src_id;
  } flit_t;

  logic  valid_q, valid_d;
  logic  rr_q, rr_d;
  flit_t flit_q, flit_d;
  logic  step;
  logic  loc_take;

  // Stage may reload when empty or when downstream pulls its flit this cycle.
  assign adv_o       = !valid_q || dn_take_i;
  assign step        = en_i && adv_o;
  assign up_take_o   = step && up_valid_i && !(loc_valid_i && rr_q);
  assign loc_ready_o = step && !(up_valid_i && !rr_q);
  assign loc_take    = loc_ready_o && loc_valid_i;

  // Next-state: pick upstream or local flit, or load an empty bubble.
  always_comb begin
    valid_d = valid_q;
    flit_d  = flit_q;
    rr_d    = rr_q;
    if (step) begin
      valid_d = up_take_o || loc_take;
      if (up_take_o) begin
        flit_d = '{data: up_data_i, src_id: up_src_i};
      end else if (loc_take) begin
        flit_d = '{data: loc_data_i, src_id: ID_WIDTH'(STAGE_ID)};
      end else begin
        flit_d = '0;
      end
      if (up_valid_i && loc_valid_i) begin
        rr_d = !rr_q;
      end
    end
  end

  // Stage registers with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      flit_q  <= '0;
      rr_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      flit_q  <= flit_d;
      rr_q    <= rr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = flit_q.data;
  assign src_o   = flit_q.src_id;
endmodule

// File: rtl/linear_network_gather_seq.sv
// Linear gather chain: node k enters at stage k, stage 0 drives the network output.
module linear_network_gather_seq
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_NODE   = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  linear_network_gather_seq_if.slave bus
);
  localparam int unsigned ID_WIDTH = id_width(NUM_NODE);

  logic                  stage_valid [NUM_NODE];
  logic [DATA_WIDTH-1:0] stage_data  [NUM_NODE];
  logic [ID_WIDTH-1:0]   stage_src   [NUM_NODE];

  for (genvar k = 0; k < NUM_NODE; k++) begin : g_stage
    logic                  up_valid;
    logic [DATA_WIDTH-1:0] up_data;
    logic [ID_WIDTH-1:0]   up_src;
    logic                  dn_take;
    logic                  take;
    logic                  adv;
    logic                  loc_ready;

    // Farthest stage has no upstream traffic.
    if (k == NUM_NODE - 1) begin : g_tail
      assign up_valid = 1'b0;
      assign up_data  = '0;
      assign up_src   = '0;
    end else begin : g_body
      assign up_valid = stage_valid[k+1];
      assign up_data  = stage_data[k+1];
      assign up_src   = stage_src[k+1];
    end

    // Stage 0 is pulled by the consumer, every other stage by its downstream neighbour.
    if (k == 0) begin : g_head
      assign dn_take = bus.i_ready;
    end else begin : g_link
      assign dn_take = g_stage[k-1].take;
    end

    gather_2x1_rr_seq #(
      .DATA_WIDTH(DATA_WIDTH),
      .ID_WIDTH  (ID_WIDTH),
      .STAGE_ID  (k)
    ) u_stage (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .en_i       (bus.i_en),
      .up_valid_i (up_valid),
      .up_data_i  (up_data),
      .up_src_i   (up_src),
      .loc_valid_i(bus.i_valid[k]),
      .loc_data_i (bus.i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
      .dn_take_i  (dn_take),
      .valid_o    (stage_valid[k]),
      .data_o     (stage_data[k]),
      .src_o      (stage_src[k]),
      .loc_ready_o(loc_ready),
      .up_take_o  (take),
      .adv_o      (adv)
    );

    assign bus.o_ready[k] = loc_ready;

    // A stage that cannot advance must accept nothing from either side.
    a_no_accept_when_stalled : assert property (
      @(posedge clk) disable iff (!rst_n) !adv |-> !(loc_ready || take)
    );
  end

  assign bus.o_valid    = stage_valid[0];
  assign bus.o_data_bus = stage_data[0];
  assign bus.o_src_id   = stage_src[0];
endmodule
